// File: rtl/rv_pkg.sv
// Shared RV64 pipeline definitions: machine width, the canonical NOP and the
// major opcodes decode switches on.
package rv_pkg;

    localparam int          XLEN     = 64;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_IMM_32 = 7'b0011011,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_REG_32 = 7'b0111011,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

endpackage

// File: rtl/if_fifo.sv
// Prefetch buffer between instruction memory and decode: synchronous FIFO
// with a clear that wins over push and pop.
module if_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    // NOTE: state registers use <= so every flop samples pre-edge values; = here would create order-dependent simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: the storage array is deliberately not reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// In-order fetch stage: credit-limited word requests to imem, prefetch FIFO
// toward decode, and squashing of responses from an abandoned path on flush.
module if_fetch_unit
    import rv_pkg::*;
#(
    parameter int                   XLEN     = rv_pkg::XLEN,
    parameter int                   DEPTH    = 4,
    parameter logic [XLEN-1:0]      RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic                    imem_ready,
    input  logic                    imem_rvalid,
    input  logic [31:0]             imem_rdata,
    input  logic                    flush,
    input  logic [XLEN-1:0]         redirect_pc,
    input  logic                    id_stall,
    output logic [31:0]             inst,
    output logic [XLEN-1:0]         inst_pc,
    output logic                    inst_valid
);
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] redirect_aligned;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_next;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   flush_discard;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic [CW:0]     stale_total;
    logic [31:0]     fifo_head;
    logic            accept;
    logic            resp;
    logic            push;
    logic            pop;

    // Every issued request holds a FIFO slot until it is consumed, so a push never meets a full FIFO.
    assign credit_used      = {1'b0, inflight} + {1'b0, fifo_count};
    assign imem_req         = !rst && !flush && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr        = fetch_pc;
    assign accept           = imem_req && imem_ready;
    assign resp             = imem_rvalid && (inflight != '0);
    assign push             = resp && (discard == '0) && !flush;
    assign inst_valid       = (fifo_count != '0);
    assign pop              = inst_valid && !id_stall && !flush;
    assign inst             = inst_valid ? fifo_head : NOP_INST;
    assign inst_pc          = out_pc;
    assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
    assign inflight_next    = inflight + CW'(accept) - CW'(resp);

    // NOTE: every always_comb output gets a default before any condition, so no path can infer a latch.
    always_comb begin
        stale_total   = {1'b0, inflight} + {1'b0, discard} - {{CW{1'b0}}, resp};
        flush_discard = stale_total[CW-1:0];
        // Stale responses can never outnumber the requests still outstanding.
        if (stale_total > {1'b0, inflight_next}) flush_discard = inflight_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            out_pc   <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight_next;
            if (flush) begin
                fetch_pc <= redirect_aligned;
                out_pc   <= redirect_aligned;
                discard  <= flush_discard;
            end else begin
                if (accept) fetch_pc <= fetch_pc + XLEN'(4);
                if (pop)    out_pc   <= out_pc + XLEN'(4);
                if (resp && (discard != '0)) discard <= discard - 1'b1;
            end
        end
    end

    if_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .wdata (imem_rdata),
        .head  (fifo_head),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a latency-programmable memory model,
// directed phases that queue expected instructions, and a pop monitor.
module tb_if_fetch_unit;
    import rv_pkg::*;

    localparam logic [63:0] RST_PC = 64'h1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        flush;
    logic [63:0] redirect_pc;
    logic        id_stall;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_valid;

    int checks    = 0;
    int errors    = 0;
    int mem_lat   = 1;
    int acc_count = 0;
    int cyc       = 0;
    int used      = 0;

    typedef struct { logic [63:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] word; logic [63:0] pc; } exp_t;

    mreq_t pend[$];
    exp_t  exp_q[$];

    if_fetch_unit #(
        .XLEN     (64),
        .DEPTH    (4),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .id_stall    (id_stall),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic exp_run(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [63:0] a;
            a = base + 64'(4 * i);
            exp_q.push_back('{mem_word(a), a});
        end
    endtask

    // Called at a falling edge; leaves rst released at the falling edge after two cycles.
    task automatic apply_reset();
        rst      = 1'b1;
        flush    = 1'b0;
        id_stall = 1'b1;
        repeat (2) @(negedge clk);
        acc_count = 0;
        rst       = 1'b0;
    endtask

    // Called at a falling edge; lets decode consume until the scoreboard empties.
    task automatic drain(input int max_cycles, output int cycles);
        cycles   = 0;
        id_stall = 1'b0;
        while (exp_q.size() != 0 && cycles < max_cycles) begin
            @(negedge clk);
            cycles++;
        end
        id_stall = 1'b1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Memory: in-order responses, mem_lat cycles after acceptance.
    initial begin
        mreq_t r;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
            if (rst) begin
                pend.delete();
            end else begin
                if (pend.size() != 0 && pend[0].due <= cyc) begin
                    r           = pend.pop_front();
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(r.addr);
                end
                if (imem_req && imem_ready) begin
                    pend.push_back('{imem_addr, cyc + mem_lat});
                    acc_count++;
                end
            end
        end
    end

    // Monitor: every consumed instruction must match the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (!inst_valid) begin
                    check("bubble_nop", 64'(inst), 64'(NOP_INST));
                end else if (!id_stall && !flush) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_inst actual=%h pc=%h expected=none", inst, inst_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("pop_inst", 64'(inst), 64'(e.word));
                        check("pop_pc", inst_pc, e.pc);
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        redirect_pc = '0;
        id_stall    = 1'b1;
        imem_ready  = 1'b1;
        mem_lat     = 1;

        // Reset state
        @(negedge clk);
        #3;
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst", 64'(inst), 64'h13);
        check("rst_pc", inst_pc, RST_PC);
        check("rst_addr", imem_addr, RST_PC);

        // Streaming from reset with single-cycle memory
        @(negedge clk);
        exp_run(RST_PC, 8);
        apply_reset();
        id_stall = 1'b0;
        #3;
        check("s_req0", 64'(imem_req), 64'd1);
        check("s_addr0", imem_addr, 64'h1000);
        check("s_valid0", 64'(inst_valid), 64'd0);
        @(negedge clk);
        #3;
        check("s_addr1", imem_addr, 64'h1004);
        check("s_valid1", 64'(inst_valid), 64'd0);
        @(negedge clk);
        #3;
        check("s_addr2", imem_addr, 64'h1008);
        check("s_valid2", 64'(inst_valid), 64'd1);
        check("s_pc2", inst_pc, 64'h1000);
        @(negedge clk);
        drain(40, used);
        check("s_rate", 64'(used), 64'd7);

        // Decode stalled: credits cap requests at DEPTH
        apply_reset();
        repeat (10) @(negedge clk);
        #3;
        check("st_accepted", 64'(acc_count), 64'd4);
        check("st_req", 64'(imem_req), 64'd0);
        check("st_inst", 64'(inst), 64'hA5A5_1000);
        check("st_pc", inst_pc, 64'h1000);
        exp_run(RST_PC, 8);
        @(negedge clk);
        drain(40, used);
        check("st_rate", 64'(used), 64'd8);
        check("st_resumed", 64'(acc_count > 4), 64'd1);

        // Memory not ready: request held, no PC advance
        imem_ready = 1'b0;
        apply_reset();
        id_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #3;
            check("nr_req", 64'(imem_req), 64'd1);
            check("nr_addr", imem_addr, 64'h1000);
            check("nr_valid", 64'(inst_valid), 64'd0);
            @(negedge clk);
        end
        imem_ready = 1'b1;
        exp_run(RST_PC, 4);
        drain(40, used);

        // Flush with three requests outstanding, misaligned target
        mem_lat = 4;
        apply_reset();
        id_stall = 1'b0;
        exp_run(64'h2000, 4);
        repeat (3) @(negedge clk);
        flush       = 1'b1;
        redirect_pc = 64'h2002;
        #3;
        check("fl_withdrawn", 64'(imem_req), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        #3;
        check("fl_req", 64'(imem_req), 64'd1);
        check("fl_addr", imem_addr, 64'h2000);
        check("fl_discard", 64'(dut.discard), 64'd3);
        check("fl_valid", 64'(inst_valid), 64'd0);
        @(negedge clk);
        drain(60, used);

        // Flush in the same cycle as a response
        mem_lat = 3;
        apply_reset();
        id_stall = 1'b0;
        exp_run(64'h3000, 3);
        repeat (3) @(negedge clk);
        flush       = 1'b1;
        redirect_pc = 64'h3000;
        @(negedge clk);
        flush = 1'b0;
        #3;
        check("fr_discard", 64'(dut.discard), 64'd2);
        check("fr_addr", imem_addr, 64'h3000);
        check("fr_valid", 64'(inst_valid), 64'd0);
        @(negedge clk);
        drain(60, used);

        // Reset with three buffered instructions
        mem_lat = 1;
        apply_reset();
        repeat (4) @(negedge clk);
        #3;
        check("mr_count", 64'(dut.fifo_count), 64'd3);
        check("mr_inst", 64'(inst), 64'hA5A5_1000);
        rst = 1'b1;
        #1;
        check("mr_valid", 64'(inst_valid), 64'd0);
        check("mr_nop", 64'(inst), 64'h13);
        check("mr_req", 64'(imem_req), 64'd0);
        @(negedge clk);
        @(negedge clk);
        exp_run(RST_PC, 2);
        acc_count = 0;
        rst       = 1'b0;
        id_stall  = 1'b0;
        #3;
        check("mr_restart", imem_addr, RST_PC);
        check("mr_req1", 64'(imem_req), 64'd1);
        @(negedge clk);
        drain(40, used);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
